trojan_response_checker: RTL and testbench

Hardware response checker for the exhaustive-pattern benchmark flow: the consuming end of the stimulus/capture stream a test harness produces while sweeping every input vector of a benchmark circuit. It holds a golden response table loaded beforehand, accepts (pattern, observed response) pairs one per cycle, and compares each against its golden entry. It counts mismatches and records the first failing pattern. It then reports pass/fail once every table entry has been exercised. Sits between the pattern sweeper and the detection result register.

---
 rtl/trojan_response_checker_pkg.sv | 22 ++
 rtl/trojan_response_checker_if.sv | 46 ++++
 rtl/trojan_response_checker_golden_table.sv | 38 +++
 rtl/trojan_response_checker.sv | 153 +++++++++++++++
 tb/tb_trojan_response_checker.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/trojan_response_checker_pkg.sv
// Shared types and constants for the exhaustive-pattern response checker.
// The MISR helper is only referenced when CHECKER_MISR_EN is defined.
package trojan_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } checker_state_t;

    localparam int DEFAULT_N_IN  = 5;
    localparam int DEFAULT_N_OUT = 1;

    // x^16 + x^12 + x^3 + x + 1, Galois form
    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
        return ({sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000)) ^ data;
    endfunction

endpackage

// File: rtl/trojan_response_checker_if.sv
// Load/capture/result bundle between the pattern sweeper and the response checker.
// The signature signal exists only when CHECKER_MISR_EN is defined.
interface trojan_response_checker_if #(
    parameter int N_IN  = trojan_checker_pkg::DEFAULT_N_IN,
    parameter int N_OUT = trojan_checker_pkg::DEFAULT_N_OUT
);
    logic              ld_valid;
    logic [N_IN-1:0]   ld_addr;
    logic [N_OUT-1:0]  ld_data;
    logic              start;
    logic              abort;
    logic              cap_valid;
    logic [N_IN-1:0]   cap_pattern;
    logic [N_OUT-1:0]  cap_resp;

    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN:0]     unk_cnt;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_pat;
    logic [N_OUT-1:0]  first_fail_resp;
`ifdef CHECKER_MISR_EN
    logic [15:0]       signature;
`endif

    modport master (
        output ld_valid, ld_addr, ld_data, start, abort, cap_valid, cap_pattern, cap_resp,
        input  busy, done, pass, mismatch_cnt, unk_cnt,
               first_fail_valid, first_fail_pat, first_fail_resp
`ifdef CHECKER_MISR_EN
        , input signature
`endif
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, start, abort, cap_valid, cap_pattern, cap_resp,
        output busy, done, pass, mismatch_cnt, unk_cnt,
               first_fail_valid, first_fail_pat, first_fail_resp
`ifdef CHECKER_MISR_EN
        , output signature
`endif
    );

endinterface

// File: rtl/trojan_response_checker_golden_table.sv
// Golden response store: register array with a loaded bitmap, one write port and
// one combinational read port. Only the bitmap is cleared by reset.
module trojan_golden_table #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             i_we,
    input  logic [N_IN-1:0]  i_waddr,
    input  logic [N_OUT-1:0] i_wdata,
    input  logic [N_IN-1:0]  i_raddr,
    output logic [N_OUT-1:0] o_rdata,
    output logic             o_loaded
);
    localparam int DEPTH = 2**N_IN;

    logic [N_OUT-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_loaded;

    always_ff @(posedge CK) begin
        if (i_we) begin
            r_data[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            r_loaded <= '0;
        end else if (i_we) begin
            r_loaded[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata  = r_data[i_raddr];
    assign o_loaded = r_loaded[i_raddr];

endmodule

// File: rtl/trojan_response_checker.sv
// Compares captured (pattern, response) pairs against a golden table until every
// pattern has been seen. Optional MISR signature under CHECKER_MISR_EN.
module trojan_response_checker
    import trojan_checker_pkg::*;
#(
    parameter int N_IN  = DEFAULT_N_IN,
    parameter int N_OUT = DEFAULT_N_OUT
) (
    input logic                      CK,
    input logic                      reset,
    trojan_response_checker_if.slave bus
);
    localparam int DEPTH = 2**N_IN;
    localparam int CNT_W = N_IN + 1;

    checker_state_t   r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_cap_cnt;
    logic [CNT_W-1:0] r_mis_cnt;
    logic [CNT_W-1:0] r_unk_cnt;
    logic [DEPTH-1:0] r_seen;
    logic             r_ff_valid;
    logic [N_IN-1:0]  r_ff_pat;
    logic [N_OUT-1:0] r_ff_resp;
`ifdef CHECKER_MISR_EN
    logic [15:0]      r_signature;
    logic [15:0]      w_misr_data;
`endif

    logic             w_we;
    logic             w_loaded;
    logic             w_mismatch;
    logic             w_unknown;
    logic [N_OUT-1:0] w_rdata;
    logic [DEPTH-1:0] w_seen_next;
    logic [CNT_W-1:0] w_cap_next;
    logic [CNT_W-1:0] w_mis_next;
    logic [CNT_W-1:0] w_unk_next;

    // Loading is only accepted while idle, including the cycle start arrives.
    assign w_we = bus.ld_valid && (r_state == IDLE) && !reset;

    trojan_golden_table #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_table (
        .CK       (CK),
        .reset    (reset),
        .i_we     (w_we),
        .i_waddr  (bus.ld_addr),
        .i_wdata  (bus.ld_data),
        .i_raddr  (bus.cap_pattern),
        .o_rdata  (w_rdata),
        .o_loaded (w_loaded)
    );

    assign w_unknown   = !w_loaded;
    assign w_mismatch  = w_loaded && (bus.cap_resp != w_rdata);
    assign w_seen_next = r_seen | (DEPTH'(1) << bus.cap_pattern);
    assign w_cap_next  = (&r_cap_cnt) ? r_cap_cnt : r_cap_cnt + 1'b1;
    assign w_mis_next  = (w_mismatch && !(&r_mis_cnt)) ? r_mis_cnt + 1'b1 : r_mis_cnt;
    assign w_unk_next  = (w_unknown  && !(&r_unk_cnt)) ? r_unk_cnt + 1'b1 : r_unk_cnt;
`ifdef CHECKER_MISR_EN
    assign w_misr_data = 16'({bus.cap_pattern, bus.cap_resp});
`endif

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_cap_cnt  <= '0;
            r_mis_cnt  <= '0;
            r_unk_cnt  <= '0;
            r_seen     <= '0;
            r_ff_valid <= 1'b0;
            r_ff_pat   <= '0;
            r_ff_resp  <= '0;
`ifdef CHECKER_MISR_EN
            r_signature <= '0;
`endif
        end else if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state    <= CHECK;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_cap_cnt  <= '0;
                        r_mis_cnt  <= '0;
                        r_unk_cnt  <= '0;
                        r_seen     <= '0;
                        r_ff_valid <= 1'b0;
                        r_ff_pat   <= '0;
                        r_ff_resp  <= '0;
`ifdef CHECKER_MISR_EN
                        r_signature <= MISR_SEED;
`endif
                    end
                end
                CHECK: begin
                    if (bus.cap_valid) begin
                        r_cap_cnt <= w_cap_next;
                        r_seen    <= w_seen_next;
                        r_mis_cnt <= w_mis_next;
                        r_unk_cnt <= w_unk_next;
`ifdef CHECKER_MISR_EN
                        r_signature <= misr_step(r_signature, w_misr_data);
`endif
                        if (w_mismatch && !r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_pat   <= bus.cap_pattern;
                            r_ff_resp  <= bus.cap_resp;
                        end
                        // Coverage completes on this capture, whose result is already folded in.
                        if (&w_seen_next) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_mis_next == '0) && (w_unk_next == '0);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.mismatch_cnt     = r_mis_cnt;
    assign bus.unk_cnt          = r_unk_cnt;
    assign bus.first_fail_valid = r_ff_valid;
    assign bus.first_fail_pat   = r_ff_pat;
    assign bus.first_fail_resp  = r_ff_resp;
`ifdef CHECKER_MISR_EN
    assign bus.signature        = r_signature;
`endif

endmodule

// File: tb/tb_trojan_response_checker.sv
// Directed bench for trojan_response_checker; exercises the signature path
// when CHECKER_MISR_EN is defined.
module tb_trojan_response_checker;

    localparam int N_IN  = 5;
    localparam int N_OUT = 1;

    logic CK = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nFails  = 0;
`ifdef CHECKER_MISR_EN
    logic [15:0] sigA;
    logic [15:0] sigB;
    logic [15:0] sigC;
`endif

    trojan_response_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    trojan_response_checker #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) dut (
        .CK    (CK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CK = ~CK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic applyStimulus(input logic capValid, input logic [N_IN-1:0] pat, input logic [N_OUT-1:0] resp);
        bus.cap_valid   = capValid;
        bus.cap_pattern = pat;
        bus.cap_resp    = resp;
        step();
    endtask

    task automatic loadEntry(input logic [N_IN-1:0] addr, input logic [N_OUT-1:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Golden table holds p[0]; flipMask bit p inverts the response sent for pattern p.
    task automatic sweep(input logic [31:0] flipMask, input string tag);
        int expMis;
        expMis = 0;
        for (int p = 0; p < 32; p++) begin
            applyStimulus(1'b1, 5'(p), 1'(p & 1) ^ flipMask[p]);
            if (flipMask[p]) expMis++;
            checkOutput({tag, " mismatch_cnt"}, 32'(bus.mismatch_cnt), 32'(expMis));
            if (p == 30) checkOutput({tag, " done before last"}, 32'(bus.done), 0);
        end
        bus.cap_valid = 1'b0;
        checkOutput({tag, " done"}, 32'(bus.done), 1);
        checkOutput({tag, " busy after done"}, 32'(bus.busy), 0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cap_valid   = 1'b0;
        bus.cap_pattern = '0;
        bus.cap_resp    = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset pass", 32'(bus.pass), 0);
        checkOutput("reset mismatch_cnt", 32'(bus.mismatch_cnt), 0);
        checkOutput("reset unk_cnt", 32'(bus.unk_cnt), 0);
        checkOutput("reset first_fail_valid", 32'(bus.first_fail_valid), 0);
`ifdef CHECKER_MISR_EN
        checkOutput("reset signature", 32'(bus.signature), 0);
`endif

        // Clean full sweep
        for (int p = 0; p < 32; p++) loadEntry(5'(p), 1'(p & 1));
        pulseStart();
        checkOutput("t1 busy after start", 32'(bus.busy), 1);
        sweep(32'h0, "t1");
        checkOutput("t1 pass", 32'(bus.pass), 1);
        checkOutput("t1 unk_cnt", 32'(bus.unk_cnt), 0);
        checkOutput("t1 first_fail_valid", 32'(bus.first_fail_valid), 0);

        // Two inverted responses, restart from DONE
        pulseStart();
        checkOutput("t2 busy", 32'(bus.busy), 1);
        checkOutput("t2 done cleared", 32'(bus.done), 0);
        sweep((32'h1 << 7) | (32'h1 << 18), "t2");
        checkOutput("t2 first_fail_pat", 32'(bus.first_fail_pat), 32'h07);
        checkOutput("t2 first_fail_resp", 32'(bus.first_fail_resp), 0);
        checkOutput("t2 first_fail_valid", 32'(bus.first_fail_valid), 1);
        checkOutput("t2 pass", 32'(bus.pass), 0);

        // Reset clears loaded bitmap; load 0..30 only
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("t3 reset mismatch_cnt", 32'(bus.mismatch_cnt), 0);
        checkOutput("t3 reset done", 32'(bus.done), 0);
        for (int p = 0; p < 31; p++) loadEntry(5'(p), 1'(p & 1));
        pulseStart();
        sweep(32'h0, "t3");
        checkOutput("t3 unk_cnt", 32'(bus.unk_cnt), 1);
        checkOutput("t3 pass", 32'(bus.pass), 0);

        // Abort from DONE keeps results; load coinciding with start still lands
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checkOutput("t4 abort done", 32'(bus.done), 0);
        checkOutput("t4 abort unk held", 32'(bus.unk_cnt), 1);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 5'd31;
        bus.ld_data  = 1'b1;
        bus.start    = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.start    = 1'b0;
        checkOutput("t4 busy", 32'(bus.busy), 1);
        checkOutput("t4 unk cleared", 32'(bus.unk_cnt), 0);

        // Pattern 3 twice with wrong response; 31 withheld
        for (int p = 0; p < 4; p++) applyStimulus(1'b1, 5'(p), (p == 3) ? 1'b0 : 1'(p & 1));
        applyStimulus(1'b1, 5'd3, 1'b0);
        for (int p = 4; p < 31; p++) applyStimulus(1'b1, 5'(p), 1'(p & 1));
        bus.cap_valid = 1'b0;
        step();
        checkOutput("t4 no done after 32", 32'(bus.done), 0);
        checkOutput("t4 still busy", 32'(bus.busy), 1);
        checkOutput("t4 mismatch_cnt", 32'(bus.mismatch_cnt), 2);
        applyStimulus(1'b1, 5'd31, 1'b1);
        bus.cap_valid = 1'b0;
        checkOutput("t4 done", 32'(bus.done), 1);
        checkOutput("t4 unk_cnt", 32'(bus.unk_cnt), 0);
        checkOutput("t4 mismatch final", 32'(bus.mismatch_cnt), 2);
        checkOutput("t4 first_fail_pat", 32'(bus.first_fail_pat), 3);
        checkOutput("t4 first_fail_resp", 32'(bus.first_fail_resp), 0);
        checkOutput("t4 pass", 32'(bus.pass), 0);

        // Abort after 10 captures; load during CHECK must be ignored
        pulseStart();
        for (int p = 0; p < 10; p++) begin
            bus.ld_valid = (p == 1);
            bus.ld_addr  = 5'd4;
            bus.ld_data  = 1'b1;
            applyStimulus(1'b1, 5'(p), (p == 2) ? 1'b1 : 1'(p & 1));
        end
        bus.ld_valid = 1'b0;
        checkOutput("t5 mismatch after 10", 32'(bus.mismatch_cnt), 1);
        bus.abort       = 1'b1;
        bus.start       = 1'b1;
        bus.cap_valid   = 1'b1;
        bus.cap_pattern = 5'd0;
        bus.cap_resp    = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.start     = 1'b0;
        bus.cap_valid = 1'b0;
        checkOutput("t5 abort busy", 32'(bus.busy), 0);
        checkOutput("t5 abort done", 32'(bus.done), 0);
        checkOutput("t5 abort mismatch held", 32'(bus.mismatch_cnt), 1);
        checkOutput("t5 abort first_fail_pat", 32'(bus.first_fail_pat), 2);
        step();
        checkOutput("t5 abort beats start", 32'(bus.busy), 0);
        pulseStart();
        checkOutput("t5 restart busy", 32'(bus.busy), 1);
        checkOutput("t5 restart mismatch", 32'(bus.mismatch_cnt), 0);
        checkOutput("t5 restart first_fail_valid", 32'(bus.first_fail_valid), 0);

        // Saturation: 70 repeated failing captures of pattern 0
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, 5'd0, 1'b1);
        bus.cap_valid = 1'b0;
        checkOutput("t6 mismatch saturated", 32'(bus.mismatch_cnt), 63);
        checkOutput("t6 still busy", 32'(bus.busy), 1);
        checkOutput("t6 first_fail_resp", 32'(bus.first_fail_resp), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;

        // Table[4] was never overwritten during CHECK
        pulseStart();
        sweep(32'h0, "t7");
        checkOutput("t7 pass", 32'(bus.pass), 1);

`ifdef CHECKER_MISR_EN
        sigA = bus.signature;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd9, 1'b0);
        bus.cap_valid = 1'b0;
        checkOutput("t8 signature frozen", 32'(bus.signature), 32'(sigA));
        pulseStart();
        sweep(32'h0, "t8b");
        sigB = bus.signature;
        checkOutput("t8 signature repeat", 32'(sigB), 32'(sigA));
        pulseStart();
        sweep(32'h1 << 9, "t8c");
        sigC = bus.signature;
        nChecks++;
        assert (sigC !== sigA) else begin
            nFails++;
            $error("[TB] FAIL t8 signature differs observed=%0h required!=%0h", sigC, sigA);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
